// File: rtl/axi_ctrl_bridge.sv
// AXI4 slave (INCR bursts, one transaction at a time) bridged onto a narrow
// single-outstanding control port. Each AXI beat becomes at most one control access.
module axi_ctrl_bridge #(
  parameter int DATA_W      = 64,
  parameter int CTRL_W      = 32,
  parameter int ID_W        = 12,
  parameter int CTRL_ADDR_W = 6
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_areset,
  input  logic [ID_W-1:0]        s_axi_awid,
  input  logic [63:0]            s_axi_awaddr,
  input  logic [7:0]             s_axi_awlen,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [DATA_W-1:0]      s_axi_wdata,
  input  logic [DATA_W/8-1:0]    s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [ID_W-1:0]        s_axi_bid,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [ID_W-1:0]        s_axi_arid,
  input  logic [63:0]            s_axi_araddr,
  input  logic [7:0]             s_axi_arlen,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [ID_W-1:0]        s_axi_rid,
  output logic [DATA_W-1:0]      s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rlast,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic                   c_valid,
  output logic                   c_we,
  output logic [CTRL_ADDR_W-1:0] c_addr,
  output logic [CTRL_W-1:0]      c_wdata,
  output logic [CTRL_W/8-1:0]    c_wstrb,
  input  logic                   c_ready,
  input  logic [CTRL_W-1:0]      c_rdata,
  input  logic                   c_err,
  output logic [2:0]             dbg_state_o
);

  localparam int BYTES    = DATA_W / 8;
  localparam int CBYTES   = CTRL_W / 8;
  localparam int BYTE_AW  = $clog2(BYTES);
  localparam int CBYTE_AW = $clog2(CBYTES);
  localparam int RATIO    = DATA_W / CTRL_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_CTRL = 3'd2,
    WR_RESP = 3'd3,
    RD_CTRL = 3'd4,
    RD_DATA = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     id_q;
  logic [63:0]         addr_q;
  logic [7:0]          cnt_q;
  logic                err_q;
  logic                wr_prio_q;
  logic [CTRL_W-1:0]   cwdata_q;
  logic [CBYTES-1:0]   cwstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          rresp_q;

  logic                aw_hs, ar_hs, oor, last;
  logic [63:0]         addr_nxt;
  int unsigned         lane;
  logic [CTRL_W-1:0]   lane_wdata;
  logic [CBYTES-1:0]   lane_wstrb;

  // All channels use valid/ready: a transfer happens on the rising edge where
  // both are high; a source holds valid and payload stable until then.
  assign aw_hs    = s_axi_awvalid & s_axi_awready;
  assign ar_hs    = s_axi_arvalid & s_axi_arready;
  assign oor      = |addr_q[63:CTRL_ADDR_W];
  assign last     = (cnt_q == 8'd0);
  assign addr_nxt = addr_q + 64'(BYTES);

  always_comb begin
    lane       = 32'(addr_q[BYTE_AW-1:0]) >> CBYTE_AW;
    lane_wdata = s_axi_wdata[lane*CTRL_W +: CTRL_W];
    lane_wstrb = s_axi_wstrb[lane*CBYTES +: CBYTES];
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_hs) state_d = WR_DATA;
               else if (ar_hs) state_d = RD_CTRL;
      // Out-of-range or fully unstrobed beats never reach the control port.
      WR_DATA: if (s_axi_wvalid) begin
                 if (oor || lane_wstrb == '0) state_d = last ? WR_RESP : WR_DATA;
                 else                         state_d = WR_CTRL;
               end
      WR_CTRL: if (c_ready) state_d = last ? WR_RESP : WR_DATA;
      WR_RESP: if (s_axi_bready) state_d = IDLE;
      RD_CTRL: if (oor || c_ready) state_d = RD_DATA;
      RD_DATA: if (s_axi_rready) state_d = last ? IDLE : RD_CTRL;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_rvalid  = 1'b0;
    c_valid       = 1'b0;
    c_we          = 1'b0;
    case (state_q)
      // Only one ready is offered when both requests are pending.
      IDLE: begin
        s_axi_awready = ~s_axi_areset & (wr_prio_q | ~s_axi_arvalid);
        s_axi_arready = ~s_axi_areset & (~wr_prio_q | ~s_axi_awvalid);
      end
      WR_DATA: s_axi_wready = 1'b1;
      WR_CTRL: begin
        c_valid = 1'b1;
        c_we    = 1'b1;
      end
      WR_RESP: s_axi_bvalid = 1'b1;
      RD_CTRL: c_valid = ~oor;
      RD_DATA: s_axi_rvalid = 1'b1;
      default: ;
    endcase
  end

  assign s_axi_bid   = id_q;
  assign s_axi_bresp = err_q ? 2'b10 : 2'b00;
  assign s_axi_rid   = id_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;
  assign s_axi_rlast = (state_q == RD_DATA) & last;
  assign c_addr      = addr_q[CTRL_ADDR_W-1:0];
  assign c_wdata     = cwdata_q;
  assign c_wstrb     = cwstrb_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      id_q      <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wr_prio_q <= 1'b1;
      cwdata_q  <= '0;
      cwstrb_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (aw_hs) begin
            id_q      <= s_axi_awid;
            addr_q    <= s_axi_awaddr;
            cnt_q     <= s_axi_awlen;
            err_q     <= 1'b0;
            wr_prio_q <= 1'b0;
          end else if (ar_hs) begin
            id_q      <= s_axi_arid;
            addr_q    <= s_axi_araddr;
            cnt_q     <= s_axi_arlen;
            wr_prio_q <= 1'b1;
          end
        end
        WR_DATA: if (s_axi_wvalid) begin
          cwdata_q <= lane_wdata;
          cwstrb_q <= lane_wstrb;
          if (oor) err_q <= 1'b1;
          if ((oor || lane_wstrb == '0) && !last) begin
            addr_q <= addr_nxt;
            cnt_q  <= cnt_q - 8'd1;
          end
        end
        WR_CTRL: if (c_ready) begin
          err_q <= err_q | c_err;
          if (!last) begin
            addr_q <= addr_nxt;
            cnt_q  <= cnt_q - 8'd1;
          end
        end
        RD_CTRL: begin
          if (oor) begin
            rdata_q <= '0;
            rresp_q <= 2'b10;
          end else if (c_ready) begin
            rdata_q <= {RATIO{c_rdata}};
            rresp_q <= c_err ? 2'b10 : 2'b00;
          end
        end
        RD_DATA: if (s_axi_rready && !last) begin
          addr_q <= addr_nxt;
          cnt_q  <= cnt_q - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ctrl_bridge.sv
// Bench for axi_ctrl_bridge: AXI drivers, a control-port responder and
// queues of expected control accesses and AXI responses.
module tb_axi_ctrl_bridge;

  localparam int ID_W = 12;

  logic             clk;
  logic             rst;
  logic [ID_W-1:0]  awid, arid, bid, rid;
  logic [63:0]      awaddr, araddr, wdata, rdata;
  logic [7:0]       awlen, arlen, wstrb;
  logic             awvalid, awready, wvalid, wready, bvalid, bready;
  logic             arvalid, arready, rvalid, rready, rlast;
  logic [1:0]       bresp, rresp;
  logic             c_valid, c_we, c_ready, c_err;
  logic [5:0]       c_addr;
  logic [31:0]      c_wdata, c_rdata;
  logic [3:0]       c_wstrb;
  logic [2:0]       dbg_state;

  axi_ctrl_bridge #(.DATA_W(64), .CTRL_W(32), .ID_W(ID_W), .CTRL_ADDR_W(6)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .c_valid(c_valid), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
    .c_ready(c_ready), .c_rdata(c_rdata), .c_err(c_err),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int total = 0;
  int bad   = 0;
  int seq   = 0;
  bit no_resp = 1'b0;
  logic [42:0] exp_c_q[$];   // {we, addr, wdata, wstrb}
  logic [32:0] rsp_q[$];     // {err, rdata}
  logic [13:0] exp_b_q[$];   // {bid, bresp}
  logic [78:0] exp_r_q[$];   // {rid, rdata, rresp, rlast}
  logic [63:0] wb_data[16];
  logic [7:0]  wb_strb[16];
  bit          wb_err[16];
  logic [31:0] rd_val[16];
  bit          rd_err[16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // control-port responder: compares each access, then answers after 0-2 cycles
  initial begin : c_side
    logic [42:0] e, snap;
    logic [32:0] r;
    int n;
    c_ready = 1'b0; c_rdata = '0; c_err = 1'b0;
    forever begin
      @(negedge clk);
      if (c_valid) begin
        if (exp_c_q.size() == 0) check("c_unexp", c_valid, 0);
        else begin
          e = exp_c_q.pop_front();
          check("c_we", c_we, e[42]);
          check("c_addr", c_addr, e[41:36]);
          if (e[42]) begin
            check("c_wdata", c_wdata, e[35:4]);
            check("c_wstrb", c_wstrb, e[3:0]);
          end
          snap = {c_we, c_addr, c_wdata, c_wstrb};
          n = no_resp ? 1000 : $urandom_range(0, 2);
          for (int i = 0; i < n && c_valid; i++) begin
            @(negedge clk);
            if (c_valid) check("c_stable", {c_we, c_addr, c_wdata, c_wstrb}, snap);
          end
          if (c_valid && !no_resp) begin
            r = (rsp_q.size() != 0) ? rsp_q.pop_front() : 33'h0;
            c_ready = 1'b1; c_err = r[32]; c_rdata = r[31:0];
            @(negedge clk);
            c_ready = 1'b0; c_err = 1'b0; c_rdata = '0;
            check("c_drop", c_valid, 0);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic send_aw(input logic [ID_W-1:0] id, input logic [63:0] addr, input logic [7:0] len);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    #1;
    while (!awready && n < 400) begin @(negedge clk); #1; n++; end
    check("aw_hs", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [63:0] addr, input int len,
                          input int bstall, output int done);
    logic [63:0] ba;
    logic [31:0] ld;
    logic [3:0]  ls;
    logic [13:0] e;
    bit err = 1'b0;
    int n;
    send_aw(id, addr, 8'(len));
    for (int i = 0; i <= len; i++) begin
      ba = addr + 64'(8 * i);
      ld = ba[2] ? wb_data[i][63:32] : wb_data[i][31:0];
      ls = ba[2] ? wb_strb[i][7:4] : wb_strb[i][3:0];
      wdata = wb_data[i]; wstrb = wb_strb[i]; wvalid = 1'b1;
      n = 0;
      #1;
      while (!wready && n < 400) begin @(negedge clk); #1; n++; end
      check("w_hs", wready, 1);
      if (|ba[63:6]) err = 1'b1;
      else if (ls != 4'h0) begin
        exp_c_q.push_back({1'b1, ba[5:0], ld, ls});
        rsp_q.push_back({wb_err[i], 32'h0});
        if (wb_err[i]) err = 1'b1;
      end
      @(negedge clk);
      wvalid = 1'b0;
    end
    exp_b_q.push_back({id, err ? 2'b10 : 2'b00});
    n = 0;
    while (!bvalid && n < 400) begin @(negedge clk); n++; end
    check("b_valid", bvalid, 1);
    e = exp_b_q.pop_front();
    for (int s = 0; s <= bstall; s++) begin
      check("bid", bid, e[13:2]);
      check("bresp", bresp, e[1:0]);
      if (s < bstall) begin @(negedge clk); check("b_hold", bvalid, 1); end
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("b_drop", bvalid, 0);
    seq++;
    done = seq;
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [63:0] addr, input int len,
                         input int rstall, output int done);
    logic [63:0] ba;
    logic [78:0] e;
    int n = 0;
    int st;
    arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
    #1;
    while (!arready && n < 400) begin @(negedge clk); #1; n++; end
    check("ar_hs", arready, 1);
    for (int i = 0; i <= len; i++) begin
      ba = addr + 64'(8 * i);
      if (|ba[63:6]) exp_r_q.push_back({id, 64'h0, 2'b10, (i == len)});
      else begin
        exp_c_q.push_back({1'b0, ba[5:0], 36'h0});
        rsp_q.push_back({rd_err[i], rd_val[i]});
        exp_r_q.push_back({id, {2{rd_val[i]}}, rd_err[i] ? 2'b10 : 2'b00, (i == len)});
      end
    end
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      n = 0;
      while (!rvalid && n < 400) begin @(negedge clk); n++; end
      check("r_valid", rvalid, 1);
      e = exp_r_q.pop_front();
      st = (i == 0) ? rstall : 0;
      for (int s = 0; s <= st; s++) begin
        check("rid", rid, e[78:67]);
        check("rdata", rdata, e[66:3]);
        check("rresp", rresp, e[2:1]);
        check("rlast", rlast, e[0]);
        if (s < st) begin @(negedge clk); check("r_hold", rvalid, 1); end
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      check("r_drop", rvalid, 0);
    end
    seq++;
    done = seq;
  endtask

  task automatic dual_pair(input logic [ID_W-1:0] wid, input logic [ID_W-1:0] rdid);
    int base, dw, dr;
    base = seq;
    wb_data[0] = {$urandom, $urandom}; wb_strb[0] = 8'hFF; wb_err[0] = 1'b0;
    rd_val[0] = $urandom; rd_err[0] = 1'b0;
    fork
      do_write(wid, 64'h20, 0, 0, dw);
      do_read(rdid, 64'h28, 0, 0, dr);
    join
    check("order_w", dw, base + 1);
    check("order_r", dr, base + 2);
  endtask

  initial begin : main
    int d, n;
    logic [63:0] a;
    int len;
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_cvalid", c_valid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    #1;
    check("idle_awready", awready, 1);
    @(negedge clk);

    // single write to the upper lane
    wb_data[0] = {32'hDEADBEEF, 32'h11111111}; wb_strb[0] = 8'hF0; wb_err[0] = 1'b0;
    do_write(12'h5A3, 64'h14, 0, 0, d);

    // four-beat read burst
    for (int i = 0; i < 4; i++) begin rd_val[i] = 32'(i + 1); rd_err[i] = 1'b0; end
    do_read(12'h0C1, 64'h0, 3, 0, d);

    // randomised bursts inside the control window
    for (int k = 0; k < 6; k++) begin
      a = 64'($urandom_range(0, 31));
      len = $urandom_range(0, 3);
      for (int i = 0; i <= len; i++) begin
        wb_data[i] = {$urandom, $urandom};
        wb_strb[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        wb_err[i]  = ($urandom_range(0, 4) == 0);
        rd_val[i]  = $urandom;
        rd_err[i]  = ($urandom_range(0, 4) == 0);
      end
      do_write(12'($urandom), a, len, $urandom_range(0, 2), d);
      do_read(12'($urandom), a, len, $urandom_range(0, 2), d);
    end

    // simultaneous requests, twice
    dual_pair(12'h111, 12'h222);
    dual_pair(12'h333, 12'h444);

    // out-of-range read, errored write burst, out-of-range write, unstrobed beat
    do_read(12'h0AA, 64'h100, 0, 0, d);
    wb_data[0] = 64'h0123456789ABCDEF; wb_strb[0] = 8'hFF; wb_err[0] = 1'b1;
    wb_data[1] = 64'hFEDCBA9876543210; wb_strb[1] = 8'hFF; wb_err[1] = 1'b0;
    do_write(12'h0BB, 64'h0, 1, 0, d);
    wb_data[0] = 64'h5555AAAA5555AAAA; wb_strb[0] = 8'hFF; wb_err[0] = 1'b0;
    do_write(12'h0CC, 64'h40, 0, 0, d);
    wb_data[0] = 64'h1; wb_strb[0] = 8'h00; wb_err[0] = 1'b1;
    wb_data[1] = 64'h0000000200000003; wb_strb[1] = 8'h0F; wb_err[1] = 1'b0;
    do_write(12'h0DD, 64'h30, 1, 0, d);

    // long response stalls
    wb_data[0] = 64'h00000000CAFE0001; wb_strb[0] = 8'h0F; wb_err[0] = 1'b0;
    do_write(12'h0EE, 64'h8, 0, 5, d);
    rd_val[0] = 32'hA5A5_0001; rd_err[0] = 1'b0;
    rd_val[1] = 32'hA5A5_0002; rd_err[1] = 1'b1;
    do_read(12'h0FF, 64'h10, 1, 5, d);

    // reset while a control write is pending
    no_resp = 1'b1;
    send_aw(12'h03C, 64'h8, 8'd0);
    wdata = 64'hCAFEF00D_12345678; wstrb = 8'h0F; wvalid = 1'b1;
    n = 0;
    #1;
    while (!wready && n < 400) begin @(negedge clk); #1; n++; end
    check("rt_w_hs", wready, 1);
    exp_c_q.push_back({1'b1, 6'h08, 32'h12345678, 4'hF});
    @(negedge clk);
    wvalid = 1'b0;
    n = 0;
    while (!c_valid && n < 50) begin @(negedge clk); n++; end
    check("rt_cvalid", c_valid, 1);
    check("rt_state", dbg_state, 2);
    #2;
    rst = 1'b1;
    #1;
    check("rt_cvalid_rst", c_valid, 0);
    check("rt_awready_rst", awready, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    no_resp = 1'b0;
    rsp_q.delete();
    #1;
    check("rt_awready", awready, 1);
    check("rt_state_idle", dbg_state, 0);
    repeat (4) begin @(negedge clk); check("rt_no_b", bvalid, 0); end

    // write priority restored by reset
    dual_pair(12'h555, 12'h666);

    check("c_left", exp_c_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_ctrl_bridge.md
AXI_CTRL_BRIDGE -- requirements
Module: axi_ctrl_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 64, AXI slave data width in bits (64 or 128).
REQ-002 SHALL have parameter CTRL_W, default 32, control-port data width in bits; DATA_W/CTRL_W is a power of two.
REQ-003 SHALL have parameter ID_W, default 12, AXI ID width.
REQ-004 SHALL have parameter CTRL_ADDR_W, default 6, control-port address width in bits.
REQ-005 SHALL have port s_axi_aclk, input, 1, the only clock; all logic is rising-edge.
REQ-006 SHALL have port s_axi_areset, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port s_axi_awid, input, ID_W, write ID.
REQ-008 SHALL have port s_axi_awaddr, input, 64, write start byte address.
REQ-009 SHALL have port s_axi_awlen, input, 8, write beats minus one.
REQ-010 SHALL have port s_axi_awvalid, input, 1, write address valid.
REQ-011 SHALL have port s_axi_awready, output, 1, write address accepted.
REQ-012 SHALL have port s_axi_wdata, input, DATA_W, write data.
REQ-013 SHALL have port s_axi_wstrb, input, DATA_W/8, write byte strobes.
REQ-014 SHALL have port s_axi_wvalid, input, 1, write data valid.
REQ-015 SHALL have port s_axi_wready, output, 1, write data accepted.
REQ-016 SHALL have port s_axi_bid, output, ID_W, write response ID.
REQ-017 SHALL have port s_axi_bresp, output, 2, write response.
REQ-018 SHALL have port s_axi_bvalid, output, 1, write response valid.
REQ-019 SHALL have port s_axi_bready, input, 1, write response accepted.
REQ-020 SHALL have port s_axi_arid, input, ID_W, read ID.
REQ-021 SHALL have port s_axi_araddr, input, 64, read start byte address.
REQ-022 SHALL have port s_axi_arlen, input, 8, read beats minus one.
REQ-023 SHALL have port s_axi_arvalid, input, 1, read address valid.
REQ-024 SHALL have port s_axi_arready, output, 1, read address accepted.
REQ-025 SHALL have port s_axi_rid, output, ID_W, read data ID.
REQ-026 SHALL have port s_axi_rdata, output, DATA_W, read data.
REQ-027 SHALL have port s_axi_rresp, output, 2, read response.
REQ-028 SHALL have port s_axi_rlast, output, 1, last read beat.
REQ-029 SHALL have port s_axi_rvalid, output, 1, read data valid.
REQ-030 SHALL have port s_axi_rready, input, 1, read data accepted.
REQ-031 SHALL have port c_valid, output, 1, control access request.
REQ-032 SHALL have port c_we, output, 1, 1 = write, 0 = read.
REQ-033 SHALL have port c_addr, output, CTRL_ADDR_W, control byte address.
REQ-034 SHALL have ports c_wdata (output, CTRL_W) and c_wstrb (output, CTRL_W/8), carrying control write data and byte strobes.
REQ-035 SHALL have port c_ready, input, 1, access complete; c_rdata and c_err are sampled in the same cycle.
REQ-036 SHALL have ports c_rdata (input, CTRL_W, control read data) and c_err (input, 1, access error).

Function
REQ-037 SHALL implement FSM states IDLE, WR_DATA, WR_CTRL, WR_RESP, RD_CTRL and RD_DATA, and SHALL process one transaction at a time.
REQ-038 SHALL assert awready and arready only in IDLE. When both awvalid and arvalid are high, the type not served last wins; after reset, write wins.
REQ-039 SHALL latch ID, address and len on the address handshake, load the beat counter with len, and advance the beat address by DATA_W/8 per beat (INCR only).
REQ-040 SHALL compute lane = addr[log2(DATA_W/8)-1 : log2(CTRL_W/8)], drive c_addr = addr[CTRL_ADDR_W-1:0], and take c_wdata/c_wstrb from that lane's slice.
REQ-041 SHALL treat a beat as out-of-range when addr[63:CTRL_ADDR_W] is nonzero; such a beat makes no c access and is flagged as an error.
REQ-042 In WR_DATA, SHALL assert wready for exactly one cycle per beat and register the lane data. A beat whose lane strobe is all-zero skips WR_CTRL.
REQ-043 SHALL hold c_valid and the c payload stable from assertion until the c_ready cycle, and SHALL deassert c_valid in the following cycle.
REQ-044 After the final write beat, SHALL drive bresp = 2'b10 if any beat had c_err or was out-of-range, else 2'b00, and SHALL hold bvalid and bid until bready.
REQ-045 SHALL return read data replicated DATA_W/CTRL_W times, with rresp = 2'b10 on c_err or out-of-range (rdata 0 for out-of-range), else 2'b00. rlast SHALL be high when the counter is 0, and rvalid/rid/rdata/rlast SHALL be held until rready.
REQ-046 SHALL have a read-beat latency from rready to the next c_valid of 1 cycle, and a write-beat latency from wvalid&wready to c_valid of 1 cycle.

Reset
REQ-047 While s_axi_areset is high, all ready, valid and data outputs SHALL be 0, the FSM SHALL be in IDLE, and write priority SHALL be set. A reset mid-transaction SHALL abandon it with no response.

Verification
REQ-048 Single write, awaddr 0x14, wdata upper lane 0xDEADBEEF, wstrb 0xF0 -> c_addr 0x14, c_wdata 0xDEADBEEF, c_wstrb 0xF, bresp 00, bid echoes awid.
REQ-049 Read burst, araddr 0x0, arlen 3, c_rdata 1/2/3/4 -> four beats, each rdata = value replicated, rlast only on beat 4, c_addr 0x0/0x8/0x10/0x18.
REQ-050 awvalid and arvalid asserted together twice -> write served first, read served second.
REQ-051 araddr 0x100 -> no c_valid, rresp 10, rdata 0; write burst of 2 with c_err on beat 1 -> single bresp 10.
REQ-052 Stall bready/rready 5 cycles -> outputs stable. Assert reset during WR_CTRL -> c_valid 0 immediately, then IDLE with awready 1.
